// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of the fetch (I) port, data (D) port and memory macro
//               signals around mem_port_arbiter.
//               slave  - arbiter view: requests and mem_rdata in; grants,
//                        responses and memory strobes out.
//               master - requester / memory view (the reverse).
// Ports       : i_req, i_addr, i_flush, i_gnt, i_rvalid, i_rdata   (fetch)
//               d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid,
//               d_rdata                                              (data)
//               mem_en, mem_we, mem_addr, mem_wdata, mem_rdata       (memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_flush;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;

   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  i_req, i_addr, i_flush,
      output i_gnt, i_rvalid, i_rdata,
      input  d_req, d_we, d_addr, d_wdata,
      output d_gnt, d_rvalid, d_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output i_req, i_addr, i_flush,
      input  i_gnt, i_rvalid, i_rdata,
      output d_req, d_we, d_addr, d_wdata,
      input  d_gnt, d_rvalid, d_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port, fixed-latency memory between the
//               fetch stage (I-port) and memory stage (D-port). One access is
//               outstanding at a time: IDLE samples requests, ISSUE strobes
//               the memory and pulses the owner's gnt, WAIT counts MEM_LAT
//               cycles, and the response pulse appears in the following IDLE
//               cycle. D wins contested decisions unless the I-port has lost
//               STARVE_MAX in a row. A fetch flush during an I access drops
//               its response.
// Ports       : clk - clock, rising edge
//               rst - asynchronous, active-low reset
//               bus - mem_port_arbiter_if.slave (I-port, D-port, memory)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  wire logic            clk,
   input  wire logic            rst,
   mem_port_arbiter_if.slave    bus
);

   localparam logic [3:0] c_LAT_LOAD   = 4'(MEM_LAT - 1);
   localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   state_t      r_state;
   owner_t      r_owner;
   logic [3:0]  r_lat_cnt;
   logic [3:0]  r_starve_cnt;
   logic        r_flushed;
   logic        r_is_write;

   logic        r_i_gnt;
   logic        r_i_rvalid;
   logic [31:0] r_i_rdata;
   logic        r_d_gnt;
   logic        r_d_rvalid;
   logic [31:0] r_d_rdata;
   logic        r_mem_en;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;

   logic        w_grant_i;
   logic        w_grant_d;
   logic        w_flush_hit;

   // I wins when uncontested, or when contested after STARVE_MAX losses.
   always_comb begin
      w_grant_i   = 1'b0;
      w_grant_d   = 1'b0;
      w_flush_hit = 1'b0;
      w_grant_i   = bus.i_req & (~bus.d_req | (r_starve_cnt == c_STARVE_MAX));
      w_grant_d   = bus.d_req & ~w_grant_i;
      // A flush only matters while an I-owned access is in flight.
      w_flush_hit = bus.i_flush & (r_owner == OWN_I);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_owner      <= OWN_NONE;
         r_lat_cnt    <= 4'd0;
         r_starve_cnt <= 4'd0;
         r_flushed    <= 1'b0;
         r_is_write   <= 1'b0;
         r_i_gnt      <= 1'b0;
         r_i_rvalid   <= 1'b0;
         r_i_rdata    <= 32'd0;
         r_d_gnt      <= 1'b0;
         r_d_rvalid   <= 1'b0;
         r_d_rdata    <= 32'd0;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= 32'd0;
         r_mem_wdata  <= 32'd0;
      end else begin
         // Every output is a one-cycle pulse / qualifier; default to 0.
         r_i_gnt     <= 1'b0;
         r_i_rvalid  <= 1'b0;
         r_i_rdata   <= 32'd0;
         r_d_gnt     <= 1'b0;
         r_d_rvalid  <= 1'b0;
         r_d_rdata   <= 32'd0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;

         case (r_state)
            S_IDLE: begin
               r_flushed <= 1'b0;
               if (w_grant_i) begin
                  r_state      <= S_ISSUE;
                  r_owner      <= OWN_I;
                  r_is_write   <= 1'b0;
                  r_starve_cnt <= 4'd0;
                  r_i_gnt      <= 1'b1;
                  r_mem_en     <= 1'b1;
                  r_mem_addr   <= bus.i_addr;
               end else if (w_grant_d) begin
                  r_state      <= S_ISSUE;
                  r_owner      <= OWN_D;
                  r_is_write   <= bus.d_we;
                  r_d_gnt      <= 1'b1;
                  r_mem_en     <= 1'b1;
                  r_mem_we     <= bus.d_we;
                  r_mem_addr   <= bus.d_addr;
                  r_mem_wdata  <= bus.d_wdata;
                  // Only a contested loss counts against the I-port.
                  if (bus.i_req) begin
                     r_starve_cnt <= r_starve_cnt + 4'd1;
                  end
               end
            end

            S_ISSUE: begin
               r_state   <= S_WAIT;
               r_lat_cnt <= c_LAT_LOAD;
               if (w_flush_hit) begin
                  r_flushed <= 1'b1;
               end
            end

            S_WAIT: begin
               if (w_flush_hit) begin
                  r_flushed <= 1'b1;
               end
               if (r_lat_cnt == 4'd0) begin
                  // mem_rdata is valid in this cycle; respond next cycle,
                  // which is already an IDLE (sampling) cycle.
                  r_state <= S_IDLE;
                  r_owner <= OWN_NONE;
                  if (r_owner == OWN_I) begin
                     if (!(r_flushed || bus.i_flush)) begin
                        r_i_rvalid <= 1'b1;
                        r_i_rdata  <= bus.mem_rdata;
                     end
                  end else if (r_owner == OWN_D) begin
                     r_d_rvalid <= 1'b1;
                     r_d_rdata  <= r_is_write ? 32'd0 : bus.mem_rdata;
                  end
               end else begin
                  r_lat_cnt <= r_lat_cnt - 4'd1;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_owner <= OWN_NONE;
            end
         endcase
      end
   end

   assign bus.i_gnt     = r_i_gnt;
   assign bus.i_rvalid  = r_i_rvalid;
   assign bus.i_rdata   = r_i_rdata;
   assign bus.d_gnt     = r_d_gnt;
   assign bus.d_rvalid  = r_d_rvalid;
   assign bus.d_rdata   = r_d_rdata;
   assign bus.mem_en    = r_mem_en;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed bench for mem_port_arbiter. Instance 1 uses
//               MEM_LAT=2 / STARVE_MAX=4; instance 2 uses MEM_LAT=1. Each has
//               a small fixed-latency memory model returning a known pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if bus1();
   mem_port_arbiter_if bus2();

   mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   // Memory contents: one fixed word, everything else derived from address.
   function automatic logic [31:0] mem_data(input logic [31:0] addr);
      if (addr == 32'h0000_0100) return 32'hDEAD_BEEF;
      return addr ^ 32'hCAFE_0000;
   endfunction

   // Latency-2 memory: data for an mem_en in cycle c is driven in cycle c+2.
   logic        m1_v0 = 1'b0, m1_v1 = 1'b0;
   logic [31:0] m1_d0 = 32'd0, m1_d1 = 32'd0;
   always @(posedge clk) begin
      m1_v0 <= bus1.mem_en;
      m1_d0 <= mem_data(bus1.mem_addr);
      m1_v1 <= m1_v0;
      m1_d1 <= m1_d0;
   end
   assign bus1.mem_rdata = m1_v1 ? m1_d1 : 32'h0BAD_0BAD;

   // Latency-1 memory.
   logic        m2_v0 = 1'b0;
   logic [31:0] m2_d0 = 32'd0;
   always @(posedge clk) begin
      m2_v0 <= bus2.mem_en;
      m2_d0 <= mem_data(bus2.mem_addr);
   end
   assign bus2.mem_rdata = m2_v0 ? m2_d0 : 32'h0BAD_0BAD;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [159:0] outs1();
      return {26'd0, bus1.i_gnt, bus1.i_rvalid, bus1.i_rdata,
              bus1.d_gnt, bus1.d_rvalid, bus1.d_rdata,
              bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata};
   endfunction

   logic exp_is_d [0:9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      bus1.i_req = 0; bus1.i_addr = 0; bus1.i_flush = 0;
      bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = 0; bus1.d_wdata = 0;
      bus2.i_req = 0; bus2.i_addr = 0; bus2.i_flush = 0;
      bus2.d_req = 0; bus2.d_we = 0; bus2.d_addr = 0; bus2.d_wdata = 0;

      // Reset state
      step(); step();
      check("reset_outputs", outs1(), 160'd0);
      rst = 1'b1;
      step();

      // Single I read (cycle 0 = sampling cycle)
      bus1.i_req = 1; bus1.i_addr = 32'h100;
      step();                                              // cycle 1
      check("rd_issue", {bus1.i_gnt, bus1.d_gnt, bus1.mem_en, bus1.mem_we, bus1.mem_addr},
            {4'b1010, 32'h100});
      bus1.i_req = 0;
      step(); step();                                      // cycle 3
      check("rd_no_early_rvalid", {bus1.i_rvalid, bus1.d_rvalid}, 2'b00);
      step();                                              // cycle 4
      check("rd_rvalid", {bus1.i_rvalid, bus1.d_rvalid, bus1.i_rdata}, {2'b10, 32'hDEAD_BEEF});
      step();
      check("rd_rvalid_pulse", bus1.i_rvalid, 1'b0);

      // D write, with an i_flush that must not affect a D access
      bus1.d_req = 1; bus1.d_we = 1; bus1.d_addr = 32'h200; bus1.d_wdata = 32'h1234_5678;
      step();                                              // cycle 1
      check("wr_issue", {bus1.i_gnt, bus1.d_gnt, bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata},
            {4'b0111, 32'h200, 32'h1234_5678});
      bus1.d_req = 0; bus1.d_we = 0;
      step();                                              // cycle 2
      bus1.i_flush = 1;
      step();                                              // cycle 3
      bus1.i_flush = 0;
      step();                                              // cycle 4
      check("wr_ack", {bus1.i_gnt, bus1.i_rvalid, bus1.d_rvalid, bus1.d_rdata}, {3'b001, 32'd0});

      // Flush of an I access, then a new fetch sampled in the response cycle
      step();
      bus1.i_req = 1; bus1.i_addr = 32'h300;
      step();                                              // cycle 1
      check("fl_gnt", {bus1.i_gnt, bus1.mem_addr}, {1'b1, 32'h300});
      bus1.i_req = 0;
      step();                                              // cycle 2
      bus1.i_flush = 1;
      step();                                              // cycle 3
      bus1.i_flush = 0;
      step();                                              // cycle 4
      check("fl_suppressed", {bus1.i_rvalid, bus1.d_rvalid}, 2'b00);
      bus1.i_req = 1; bus1.i_addr = 32'h400;
      step();                                              // cycle 5
      check("fl_next_issue", {bus1.i_gnt, bus1.mem_en, bus1.mem_addr}, {2'b11, 32'h400});
      bus1.i_req = 0;
      step(); step(); step();                              // cycle 8
      check("fl_next_rvalid", {bus1.i_rvalid, bus1.i_rdata}, {1'b1, 32'hCAFE_0400});

      // Reset in the middle of a D read
      step();
      bus1.d_req = 1; bus1.d_we = 0; bus1.d_addr = 32'h500;
      step();                                              // cycle 1
      check("rst_gnt", {bus1.d_gnt, bus1.mem_addr}, {1'b1, 32'h500});
      bus1.d_req = 0;
      step();                                              // cycle 2
      rst = 1'b0;
      #1;
      check("rst_async_outputs", outs1(), 160'd0);
      step();                                              // cycle 3
      rst = 1'b1;
      step();                                              // cycle 4
      check("rst_no_rvalid_c4", {bus1.d_rvalid, bus1.i_rvalid}, 2'b00);
      step();                                              // cycle 5
      check("rst_no_rvalid_c5", {bus1.d_rvalid, bus1.i_rvalid}, 2'b00);
      bus1.d_req = 1; bus1.d_addr = 32'h600;
      step();
      check("rst_new_gnt", {bus1.d_gnt, bus1.mem_addr}, {1'b1, 32'h600});
      bus1.d_req = 0;
      step(); step(); step();
      check("rst_new_rvalid", {bus1.d_rvalid, bus1.d_rdata}, {1'b1, 32'hCAFE_0600});

      // Contention with starvation relief: D,D,D,D,I,D,D,D,D,I
      step();
      bus1.i_req = 1; bus1.i_addr = 32'h700;
      bus1.d_req = 1; bus1.d_we = 0; bus1.d_addr = 32'h800;
      for (int g = 0; g < 10; g++) begin
         step();
         check("cont_gnt", {bus1.i_gnt, bus1.d_gnt}, exp_is_d[g] ? 2'b01 : 2'b10);
         step();
         check("cont_gap", {bus1.i_gnt, bus1.d_gnt}, 2'b00);
         step(); step();
         check("cont_rvalid", {bus1.i_rvalid, bus1.d_rvalid}, exp_is_d[g] ? 2'b01 : 2'b10);
         check("cont_rdata", exp_is_d[g] ? bus1.d_rdata : bus1.i_rdata,
               exp_is_d[g] ? 32'hCAFE_0800 : 32'hCAFE_0700);
      end
      bus1.i_req = 0; bus1.d_req = 0;
      step(); step();
      check("cont_idle", {bus1.i_gnt, bus1.d_gnt, bus1.mem_en}, 3'b000);

      // MEM_LAT=1, back-to-back fetches: gnt every 3 cycles, rvalid gnt+2
      bus2.i_req = 1; bus2.i_addr = 32'h900;
      for (int g = 0; g < 3; g++) begin
         step();
         check("lat1_gnt", {bus2.i_gnt, bus2.mem_en, bus2.mem_addr}, {2'b11, 32'h900});
         step();
         check("lat1_wait", {bus2.i_gnt, bus2.i_rvalid}, 2'b00);
         step();
         check("lat1_rvalid", {bus2.i_rvalid, bus2.i_rdata}, {1'b1, 32'hCAFE_0900});
      end
      bus2.i_req = 0;
      step();
      check("lat1_idle", {bus2.i_gnt, bus2.i_rvalid, bus2.d_gnt}, 3'b000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the fetch stage (I-port) and the memory stage (D-port) of the 5-stage RISC-V pipeline.
- Arbitrates between the two ports, sequences a single outstanding memory access, and returns responses to the owning port.
- Discards fetch responses when a taken branch (PCSrcE) flushes the fetch stream.
- Sits between the fetch/memory stage logic and the memory macro.

Parameters:
- MEM_LAT, 2, memory read latency in cycles from the mem_en cycle to valid mem_rdata (legal range 1..15).
- STARVE_MAX, 4, consecutive lost arbitrations after which the I-port wins the next contested decision (legal range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request.
- i_addr  in  32  fetch address.
- i_flush  in  1  fetch flush (PCSrcE).
- i_gnt  out  1  fetch request accepted, 1-cycle pulse.
- i_rvalid  out  1  fetch data valid, 1-cycle pulse.
- i_rdata  out  32  fetch data.
- d_req  in  1  data request.
- d_we  in  1  data write when 1, read when 0.
- d_addr  in  32  data address.
- d_wdata  in  32  write data.
- d_gnt  out  1  data request accepted, 1-cycle pulse.
- d_rvalid  out  1  read data valid / write acknowledge, 1-cycle pulse.
- d_rdata  out  32  read data (0 on write acks).
- mem_en  out  1  memory access strobe, 1 cycle.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- All outputs are registered. During and after reset, every output is 0, the state is IDLE, the starvation counter is 0, and the owner is cleared.
- FSM states:
  - IDLE: requests are sampled here only.
  - ISSUE: mem_en, mem_we, mem_addr and mem_wdata driven for 1 cycle; the owner's gnt pulses in the same cycle.
  - WAIT: a latency counter runs MEM_LAT cycles.
  - RESP: the owner's rvalid pulses with rdata = mem_rdata captured at cycle mem_en+MEM_LAT; the FSM is in IDLE again in this cycle.
- Timing: request sampled high at edge of cycle T (IDLE) -> ISSUE/gnt/mem_en in T+1 -> mem_rdata valid T+1+MEM_LAT -> rvalid in T+2+MEM_LAT.
- Back-to-back throughput: 1 access per MEM_LAT+2 cycles.
- The RESP/IDLE cycle samples requests, so a held req starts the next access immediately.
- Requesters hold req, addr, we and wdata stable until gnt. req during ISSUE/WAIT is ignored. The requester must deassert or re-present req with the new address by its rvalid cycle.
- Arbitration (only when both req are sampled high):
  - D wins by default and the starvation counter increments.
  - When the counter equals STARVE_MAX, I wins and the counter clears.
  - An uncontested I grant also clears the counter. An uncontested D grant leaves it unchanged.
- Flush:
  - i_flush high in any cycle from ISSUE through the return cycle (T+1+MEM_LAT) of an I-owned access suppresses that access's i_rvalid; the FSM still waits the full latency.
  - i_flush has no effect on D-owned accesses or in IDLE with no I access outstanding. i_req in the same cycle is still arbitrated normally.
- D writes occupy the full latency; d_rvalid acks with d_rdata = 0. mem_we is 0 for all I accesses.
- Only one of i_gnt/d_gnt and one of i_rvalid/d_rvalid is ever high in a cycle.
- Reset mid-access (any state): immediate return to IDLE, all outputs 0, no rvalid for the abandoned access, and late mem_rdata is ignored.

Test Plan:
- Single I read, MEM_LAT=2:
  - Stimulus: i_req=1, i_addr=0x100 sampled in cycle 0.
  - Response: cycle 1 has mem_en=1, mem_addr=0x100, i_gnt=1. Memory returns 0xDEADBEEF in cycle 3. Cycle 4 has i_rvalid=1, i_rdata=0xDEADBEEF.
- Contention and starvation, STARVE_MAX=4:
  - Stimulus: i_req and d_req held high continuously.
  - Response: grants are D,D,D,D,I,D,D,D,D,I…, with grants spaced 4 cycles apart.
- D write:
  - Stimulus: d_we=1, d_addr=0x200, d_wdata=0x12345678.
  - Response: mem_en=1, mem_we=1 with those values in cycle 1. d_rvalid=1, d_rdata=0 in cycle 4. No i_* activity.
- Flush:
  - Stimulus: I access to 0x300, with i_flush=1 in cycle 2.
  - Response: no i_rvalid in cycle 4. A new i_req for 0x400 sampled in cycle 4 produces mem_en in cycle 5.
- Reset mid-access:
  - Stimulus: assert rst=0 in cycle 2 of a D read.
  - Response: all outputs 0 immediately. After release, no d_rvalid appears. A new request completes normally with 4-cycle latency.
- MEM_LAT=1 with back-to-back I requests:
  - Stimulus: I requests held back-to-back.
  - Response: i_gnt every 3 cycles, i_rvalid 2 cycles after each gnt.
